// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the keypad display multiplexer.
//   disp_state_t : display phase sequence SHOW_L -> BLANK_L -> SHOW_R -> BLANK_R.
//   SEG_OFF      : all segments dark (active-low drive).
//   AN_*         : active-low anode patterns; bit1 = left digit, bit0 = right digit.
package display_pkg;

   typedef enum logic [1:0] {
      SHOW_L  = 2'd0,
      BLANK_L = 2'd1,
      SHOW_R  = 2'd2,
      BLANK_R = 2'd3
   } disp_state_t;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [1:0] AN_OFF   = 2'b11;
   localparam logic [1:0] AN_LEFT  = 2'b01;
   localparam logic [1:0] AN_RIGHT = 2'b10;

endpackage

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder
//   Combinational hex to seven-segment decoder for a common-anode display.
//   Ports:
//     hex    in  4  nibble to display (0-F, lower-case b and d)
//     seg_n  out 7  active-low segments, bit0 = a ... bit6 = g
module sevenseg_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = 7'h7F;
      case (hex)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         4'hF: seg_n = 7'h0E;
         default: seg_n = 7'h7F;
      endcase
   end

endmodule

// File: rtl/keypad_display_mux.sv
// keypad_display_mux
//   Keeps a two-digit history of accepted keypad codes and time-multiplexes it
//   onto a dual common-anode seven-segment display, with a dark interval
//   between the left and right phases to suppress ghosting.
//   Parameters:
//     REFRESH_DIV   clk cycles per SHOW phase (>= 1)
//     BLANK_CYCLES  clk cycles per BLANK phase (>= 1)
//   Ports:
//     clk        in  1  system clock, rising edge
//     reset      in  1  synchronous, active-high, overrides all inputs
//     digit      in  4  key code, captured when a key is accepted
//     valid_key  in  1  key strobe; only its rising edge is accepted
//     seg_n      out 7  active-low segments, bit0 = a ... bit6 = g
//     an_n       out 2  active-low anodes, bit1 = left, bit0 = right
module keypad_display_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 24000,
   parameter int BLANK_CYCLES = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit,
   input  logic       valid_key,
   output logic [6:0] seg_n,
   output logic [1:0] an_n
);

   localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   disp_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       left_dig_q, left_dig_d;
   logic [3:0]       right_dig_q, right_dig_d;
   logic             left_vld_q, left_vld_d;
   logic             right_vld_q, right_vld_d;
   logic             valid_prev_q, valid_prev_d;
   logic [6:0]       seg_n_q, seg_n_d;
   logic [1:0]       an_n_q, an_n_d;

   logic             key_accept;
   logic             phase_last;
   logic [3:0]       dec_in;
   logic [6:0]       dec_seg;

   // Key capture: rising edge of valid_key shifts right digit into left.
   always_comb begin
      key_accept   = valid_key & ~valid_prev_q;
      valid_prev_d = valid_key;
      left_dig_d   = left_dig_q;
      left_vld_d   = left_vld_q;
      right_dig_d  = right_dig_q;
      right_vld_d  = right_vld_q;
      if (key_accept) begin
         left_dig_d  = right_dig_q;
         left_vld_d  = right_vld_q;
         right_dig_d = digit;
         right_vld_d = 1'b1;
      end
   end

   // Display FSM next state: one shared counter, cleared on every transition.
   always_comb begin
      if (state_q == SHOW_L || state_q == SHOW_R) begin
         phase_last = (cnt_q == SHOW_LAST);
      end else begin
         phase_last = (cnt_q == BLANK_LAST);
      end

      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      if (phase_last) begin
         cnt_d = '0;
         case (state_q)
            SHOW_L:  state_d = BLANK_L;
            BLANK_L: state_d = SHOW_R;
            SHOW_R:  state_d = BLANK_R;
            BLANK_R: state_d = SHOW_L;
            default: state_d = SHOW_L;
         endcase
      end
   end

   // Single decoder shared by both positions; its input follows the phase
   // being entered.
   assign dec_in = (state_d == SHOW_L) ? left_dig_q : right_dig_q;

   sevenseg_decoder u_decoder (
      .hex   (dec_in),
      .seg_n (dec_seg)
   );

   // Output comb: driven from the upcoming phase so anodes switch exactly at
   // the phase boundary. History is taken from the current registers, so a
   // newly accepted key reaches the segments one cycle after its accept edge.
   always_comb begin
      an_n_d  = AN_OFF;
      seg_n_d = SEG_OFF;
      case (state_d)
         SHOW_L: begin
            an_n_d  = AN_LEFT;
            seg_n_d = left_vld_q ? dec_seg : SEG_OFF;
         end
         SHOW_R: begin
            an_n_d  = AN_RIGHT;
            seg_n_d = right_vld_q ? dec_seg : SEG_OFF;
         end
         default: begin
            an_n_d  = AN_OFF;
            seg_n_d = SEG_OFF;
         end
      endcase
   end

   // State register: all flops, reset has priority over key capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SHOW_L;
         cnt_q        <= '0;
         left_dig_q   <= 4'h0;
         right_dig_q  <= 4'h0;
         left_vld_q   <= 1'b0;
         right_vld_q  <= 1'b0;
         valid_prev_q <= 1'b0;
         seg_n_q      <= SEG_OFF;
         an_n_q       <= AN_OFF;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         left_dig_q   <= left_dig_d;
         right_dig_q  <= right_dig_d;
         left_vld_q   <= left_vld_d;
         right_vld_q  <= right_vld_d;
         valid_prev_q <= valid_prev_d;
         seg_n_q      <= seg_n_d;
         an_n_q       <= an_n_d;
      end
   end

   assign seg_n = seg_n_q;
   assign an_n  = an_n_q;

endmodule

// File: tb/tb_keypad_display_mux.sv
// tb_keypad_display_mux
//   Scoreboard bench: every stimulus cycle pushes the expected registered
//   outputs derived from a phase timeline and a two-digit history model;
//   each scenario task pops and compares after the clock edge.
module tb_keypad_display_mux;

   localparam int RD     = 4;
   localparam int BC     = 2;
   localparam int PERIOD = 2 * (RD + BC);

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic       vk;
      logic [3:0] dg;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] digit = 4'h0;
   logic       valid_key = 1'b0;
   logic [6:0] seg_n;
   logic [1:0] an_n;

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];

   // Reference model state
   int         pos = 0;
   logic [3:0] m_left = 4'h0, m_right = 4'h0;
   logic       m_lv = 1'b0, m_rv = 1'b0, m_prev = 1'b0;

   keypad_display_mux #(
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .digit     (digit),
      .valid_key (valid_key),
      .seg_n     (seg_n),
      .an_n      (an_n)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
      $fatal(1);
   end

   function automatic logic [6:0] ref_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Drive one cycle, push the expected outputs for the coming edge, advance
   // past the edge and update the model.
   task automatic tick(input logic rst_i, input logic vk_i, input logic [3:0] dg_i);
      exp_t e;
      int   np;
      reset     = rst_i;
      valid_key = vk_i;
      digit     = dg_i;
      np        = (pos + 1) % PERIOD;
      if (rst_i) begin
         e.an  = 2'b11;
         e.seg = 7'h7F;
      end else if (np < RD) begin
         e.an  = 2'b01;
         e.seg = m_lv ? ref_seg(m_left) : 7'h7F;
      end else if (np < RD + BC) begin
         e.an  = 2'b11;
         e.seg = 7'h7F;
      end else if (np < 2 * RD + BC) begin
         e.an  = 2'b10;
         e.seg = m_rv ? ref_seg(m_right) : 7'h7F;
      end else begin
         e.an  = 2'b11;
         e.seg = 7'h7F;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (rst_i) begin
         pos = 0;
         m_left = 4'h0; m_right = 4'h0;
         m_lv = 1'b0; m_rv = 1'b0; m_prev = 1'b0;
      end else begin
         pos = np;
         if (vk_i && !m_prev) begin
            m_left  = m_right;
            m_lv    = m_rv;
            m_right = dg_i;
            m_rv    = 1'b1;
         end
         m_prev = vk_i;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL reset cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_idle_refresh();
      exp_t e;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL idle cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_single_key();
      exp_t  e;
      step_t s[$];
      s.push_back('{1'b0, 1'b1, 4'h3});
      for (int i = 0; i < PERIOD + 2; i++) s.push_back('{1'b0, 1'b0, 4'h3});
      foreach (s[i]) begin
         tick(s[i].rst, s[i].vk, s[i].dg);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL single_key cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_two_keys();
      exp_t  e;
      step_t s[$];
      s.push_back('{1'b1, 1'b0, 4'h0});
      s.push_back('{1'b0, 1'b1, 4'h3});
      s.push_back('{1'b0, 1'b0, 4'h0});
      s.push_back('{1'b0, 1'b1, 4'hA});
      for (int i = 0; i < PERIOD; i++) s.push_back('{1'b0, 1'b0, 4'h0});
      s.push_back('{1'b0, 1'b1, 4'hE});
      for (int i = 0; i < PERIOD; i++) s.push_back('{1'b0, 1'b0, 4'h0});
      foreach (s[i]) begin
         tick(s[i].rst, s[i].vk, s[i].dg);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL two_keys cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_held_key();
      exp_t  e;
      step_t s[$];
      s.push_back('{1'b1, 1'b0, 4'h0});
      s.push_back('{1'b0, 1'b1, 4'h0});
      s.push_back('{1'b0, 1'b0, 4'h0});
      s.push_back('{1'b0, 1'b1, 4'h1});
      s.push_back('{1'b0, 1'b0, 4'h0});
      for (int i = 0; i < 5; i++) s.push_back('{1'b0, 1'b1, 4'h7});
      for (int i = 0; i < PERIOD + 2; i++) s.push_back('{1'b0, 1'b0, 4'h0});
      foreach (s[i]) begin
         tick(s[i].rst, s[i].vk, s[i].dg);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL held_key cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_accept_show_r();
      exp_t e;
      int   show_r_cnt;
      // Advance to the first SHOW_R cycle (bounded).
      for (int i = 0; i < PERIOD && pos != RD + BC; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL show_r_approach cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
      show_r_cnt = (an_n === 2'b10) ? 1 : 0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, (i == 0), 4'h1);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL show_r_accept cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
         if (i == 1) begin
            checks++;
            if ({an_n, seg_n} !== {2'b10, 7'h79}) begin
               errors++;
               $display("FAIL show_r_new_digit: an_n=%b seg_n=%h expected an_n=10 seg_n=79", an_n, seg_n);
            end
         end
         if (an_n === 2'b10) show_r_cnt++;
      end
      checks++;
      if (show_r_cnt != RD) begin
         errors++;
         $display("FAIL show_r_length: got %0d cycles expected %0d", show_r_cnt, RD);
      end
   endtask

   task automatic test_accept_last_cycle();
      exp_t e;
      // Reach the last SHOW_L cycle, then accept on the transition edge.
      for (int i = 0; i < PERIOD + 1 && pos != RD - 1; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL last_cycle_approach cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
      for (int i = 0; i < PERIOD + 1; i++) begin
         tick(1'b0, (i == 0), 4'h5);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL last_cycle cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   task automatic test_reset_with_key();
      exp_t e;
      for (int i = 0; i < PERIOD && pos != RD + BC + 1; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL rst_key_approach cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
      tick(1'b1, 1'b1, 4'h5);
      e = sb_q.pop_front();
      checks++;
      if ({an_n, seg_n} !== {2'b11, 7'h7F}) begin
         errors++;
         $display("FAIL rst_key_edge: an_n=%b seg_n=%h expected an_n=11 seg_n=7f", an_n, seg_n);
      end
      for (int i = 0; i < PERIOD + 2; i++) begin
         tick(1'b0, 1'b0, 4'h0);
         e = sb_q.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL rst_key_after cyc%0d: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", i, an_n, seg_n, e.an, e.seg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_refresh();
      test_single_key();
      test_two_keys();
      test_held_key();
      test_accept_show_r();
      test_accept_last_cycle();
      test_reset_with_key();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
